// File: rtl/divs_seq_if.sv
// Request/result bundle of the sequential unsigned divider.
// The master drives the operands and start; the slave (divs_seq) returns the results and status.
interface divs_seq_if #(
  parameter int WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/divs_seq.sv
// Sequential restoring divider: one quotient bit per cycle, fixed latency.
// A zero divisor skips the iterations and reports quotient = all ones, remainder = dividend.
module divs_seq #(
  parameter int WIDTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  divs_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_prem;
  logic [WIDTH-1:0] r_wquo;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic [CW-1:0]    r_count;
  logic             r_busy;
  logic             r_done;
  logic             r_dbz;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;

  // Restoring step: shift next dividend bit into the partial remainder, trial-subtract.
  always_comb begin
    w_trial  = {r_prem, r_wquo[WIDTH-1]};
    w_borrow = (w_trial < {1'b0, r_divisor});
    w_diff   = w_trial - {1'b0, r_divisor};
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor == {WIDTH{1'b0}}) begin
            w_state_next = S_DONE;
          end else begin
            w_state_next = S_CALC;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_CALC: begin
        if (r_count == CW'(1)) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_CALC;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath; status flags and results register one cycle behind the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_divisor   <= {WIDTH{1'b0}};
      r_prem      <= {WIDTH{1'b0}};
      r_wquo      <= {WIDTH{1'b0}};
      r_quotient  <= {WIDTH{1'b0}};
      r_remainder <= {WIDTH{1'b0}};
      r_count     <= {CW{1'b0}};
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      r_busy <= (r_state == S_CALC);
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_divisor <= bus.divisor;
            r_count   <= CW'(WIDTH);
            if (bus.divisor == {WIDTH{1'b0}}) begin
              r_wquo <= {WIDTH{1'b1}};
              r_prem <= bus.dividend;
              r_dbz  <= 1'b1;
            end else begin
              r_wquo <= bus.dividend;
              r_prem <= {WIDTH{1'b0}};
              r_dbz  <= 1'b0;
            end
          end
        end
        S_CALC: begin
          r_prem  <= w_borrow ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
          r_wquo  <= {r_wquo[WIDTH-2:0], ~w_borrow};
          r_count <= r_count - CW'(1);
        end
        S_DONE: begin
          r_quotient  <= r_wquo;
          r_remainder <= r_prem;
        end
        default: begin
          r_count <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
endmodule
